// File: rtl/pio_edge_event_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pio_edge_event_sequencer_if
// Brief    : Memory-mapped register bus between the sequencer and a PIO core.
// Revision : 1.0
// ============================================================================
interface pio_edge_event_sequencer_if;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address,
    output m_chipselect,
    output m_write_n,
    output m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_chipselect,
    input  m_write_n,
    input  m_writedata,
    output m_readdata
  );
endinterface
`default_nettype wire

// File: rtl/pio_edge_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pio_edge_event_sequencer
// Brief    : Services PIO edge interrupts and queues {edges, level} events.
// Revision : 1.0
// ============================================================================
module pio_edge_event_sequencer #(
  parameter int WIDTH      = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [WIDTH-1:0]                  cfg_mask,
  input  logic                              cfg_start,
  input  logic                              pio_irq,
  pio_edge_event_sequencer_if.master        pio,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [WIDTH-1:0]                  evt_edges,
  output logic [WIDTH-1:0]                  evt_level,
  output logic [7:0]                        spurious_cnt,
  output logic                              busy
);

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_MASK   = 4'd1,
    WAIT_IRQ  = 4'd2,
    RD_CAP    = 4'd3,
    LATCH_CAP = 4'd4,
    WR_CLR    = 4'd5,
    RD_LVL    = 4'd6,
    LATCH_LVL = 4'd7,
    PUSH      = 4'd8
  } state_e;

  state_e               state_q, state_d;
  logic                 start_pend_q, start_pend_d;
  logic [WIDTH-1:0]     cfg_mask_q;
  logic [WIDTH-1:0]     act_mask_q;
  logic [WIDTH-1:0]     cap_q;
  logic [WIDTH-1:0]     lvl_q;
  logic [7:0]           spur_q;
  logic [PTR_W:0]       wr_ptr_q;
  logic [PTR_W:0]       rd_ptr_q;
  logic [2*WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic                 w_start_req;
  logic                 w_cap_ld;
  logic                 w_lvl_ld;
  logic                 w_mask_ld;
  logic                 w_push;
  logic                 w_spur_inc;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic [2*WIDTH-1:0]   w_head;

  // Upper read-data bits are never used when the PIO is narrower than the bus.
  generate
    if (WIDTH < 32) begin : g_rd_pad
      logic w_unused_rdata;
      assign w_unused_rdata = ^pio.m_readdata[31:WIDTH];
    end
  endgenerate

  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign evt_valid = ~w_empty;
  assign w_pop     = evt_valid & evt_ready;
  assign w_head    = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign evt_edges = w_head[2*WIDTH-1:WIDTH];
  assign evt_level = w_head[WIDTH-1:0];

  assign spurious_cnt = spur_q;
  assign busy         = (state_q != IDLE) && (state_q != WAIT_IRQ);
  assign w_start_req  = cfg_start | start_pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A capture sequence is atomic once started (the PIO clear happens mid-way),
  // so a deferred start is only honoured where the FSM would rest in WAIT_IRQ.
  always_comb begin
    state_d          = state_q;
    pio.m_address    = 2'd0;
    pio.m_chipselect = 1'b0;
    pio.m_write_n    = 1'b1;
    pio.m_writedata  = 32'd0;
    w_cap_ld         = 1'b0;
    w_lvl_ld         = 1'b0;
    w_mask_ld        = 1'b0;
    w_push           = 1'b0;
    w_spur_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) state_d = WR_MASK;
      end
      WR_MASK: begin
        pio.m_address    = 2'd2;
        pio.m_chipselect = 1'b1;
        pio.m_write_n    = 1'b0;
        pio.m_writedata  = 32'(cfg_mask_q);
        w_mask_ld        = 1'b1;
        state_d          = w_start_req ? WR_MASK : WAIT_IRQ;
      end
      WAIT_IRQ: begin
        if (w_start_req)              state_d = WR_MASK;
        else if (pio_irq && !w_full)  state_d = RD_CAP;
      end
      RD_CAP: begin
        pio.m_address    = 2'd3;
        pio.m_chipselect = 1'b1;
        state_d          = LATCH_CAP;
      end
      LATCH_CAP: begin
        pio.m_address    = 2'd3;
        pio.m_chipselect = 1'b1;
        pio.m_write_n    = 1'b0;
        w_cap_ld         = 1'b1;
        state_d          = RD_LVL;
      end
      RD_LVL: begin
        pio.m_address    = 2'd0;
        pio.m_chipselect = 1'b1;
        state_d          = LATCH_LVL;
      end
      LATCH_LVL: begin
        w_lvl_ld = 1'b1;
        if (cap_q != '0) begin
          state_d = PUSH;
        end else begin
          w_spur_inc = 1'b1;
          state_d    = w_start_req ? WR_MASK : WAIT_IRQ;
        end
      end
      PUSH: begin
        w_push  = 1'b1;
        state_d = w_start_req ? WR_MASK : WAIT_IRQ;
      end
      WR_CLR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_pend_d = (start_pend_q | cfg_start) && (state_d != WR_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_pend_q <= 1'b0;
      cfg_mask_q   <= '0;
      act_mask_q   <= '0;
      cap_q        <= '0;
      lvl_q        <= '0;
      spur_q       <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      start_pend_q <= start_pend_d;
      if (cfg_start) cfg_mask_q <= cfg_mask;
      if (w_mask_ld) act_mask_q <= cfg_mask_q;
      if (w_cap_ld)  cap_q      <= pio.m_readdata[WIDTH-1:0] & act_mask_q;
      if (w_lvl_ld)  lvl_q      <= pio.m_readdata[WIDTH-1:0];
      if (w_spur_inc && (spur_q != 8'hFF)) spur_q <= spur_q + 8'd1;
      if (w_push)    wr_ptr_q   <= wr_ptr_q + PTR_ONE;
      if (w_pop)     rd_ptr_q   <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {cap_q, lvl_q};
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_edge_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_edge_event_sequencer
// Brief    : Directed bench with a behavioural PIO (edge capture, irq mask).
// Revision : 1.0
// ============================================================================
module tb_pio_edge_event_sequencer;
  localparam int W = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pio_rst_n;
  logic [W-1:0]  cfg_mask;
  logic          cfg_start;
  logic          pio_irq;
  logic          force_irq;
  logic          evt_valid;
  logic          evt_ready;
  logic [W-1:0]  evt_edges;
  logic [W-1:0]  evt_level;
  logic [7:0]    spurious_cnt;
  logic          busy;

  logic [W-1:0]  pio_in;
  logic [W-1:0]  prev_in;
  logic [W-1:0]  edgecap;
  logic [W-1:0]  irqmask;
  logic [31:0]   rdata;
  logic [31:0]   last_wr2;
  int            n_acc;
  int            n_wr2;
  int            n_clr;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pio_edge_event_sequencer_if bus ();

  pio_edge_event_sequencer #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_mask     (cfg_mask),
    .cfg_start    (cfg_start),
    .pio_irq      (pio_irq),
    .pio          (bus),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_edges    (evt_edges),
    .evt_level    (evt_level),
    .spurious_cnt (spurious_cnt),
    .busy         (busy)
  );

  // Behavioural PIO: falling-edge capture, clear on write to address 3.
  always @(posedge clk) begin
    if (!pio_rst_n) begin
      prev_in  <= '1;
      edgecap  <= '0;
      irqmask  <= '0;
      rdata    <= '0;
      last_wr2 <= '0;
      n_acc    <= 0;
      n_wr2    <= 0;
      n_clr    <= 0;
    end else begin
      prev_in <= pio_in;
      if (bus.m_chipselect) n_acc <= n_acc + 1;
      if (bus.m_chipselect && bus.m_write_n) begin
        case (bus.m_address)
          2'd0:    rdata <= 32'(pio_in);
          2'd2:    rdata <= 32'(irqmask);
          2'd3:    rdata <= 32'(edgecap);
          default: rdata <= 32'd0;
        endcase
      end
      if (bus.m_chipselect && !bus.m_write_n && bus.m_address == 2'd3) begin
        edgecap <= '0;
        n_clr   <= n_clr + 1;
      end else begin
        edgecap <= edgecap | (prev_in & ~pio_in);
      end
      if (bus.m_chipselect && !bus.m_write_n && bus.m_address == 2'd2) begin
        irqmask  <= bus.m_writedata[W-1:0];
        last_wr2 <= bus.m_writedata;
        n_wr2    <= n_wr2 + 1;
      end
    end
  end

  assign bus.m_readdata = rdata;
  assign pio_irq        = (|(edgecap & irqmask)) | force_irq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [W-1:0] m);
    cfg_mask  = m;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic pop();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic make_event(input int bit_idx);
    pio_in = '1;
    pio_in[bit_idx] = 1'b0;
    repeat (12) tick();
    pio_in = '1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pio_rst_n = 1'b0; cfg_start = 1'b0; cfg_mask = '0;
    evt_ready = 1'b0; force_irq = 1'b0; pio_in = '1;
    repeat (3) tick();
    total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", evt_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (bus.m_chipselect !== 1'b0 || bus.m_write_n !== 1'b1)
      $display("FAIL reset_bus_ctl: got cs=%b wn=%b want cs=0 wn=1", bus.m_chipselect, bus.m_write_n); else passed++;
    total++; if (bus.m_address !== 2'd0 || bus.m_writedata !== 32'd0)
      $display("FAIL reset_bus_data: got addr=%0d wd=%h want 0/0", bus.m_address, bus.m_writedata); else passed++;
    total++; if (spurious_cnt !== 8'd0) $display("FAIL reset_spurious: got %0d want 0", spurious_cnt); else passed++;
    reset_n = 1'b1; pio_rst_n = 1'b1;
    repeat (4) tick();
    total++; if (n_acc !== 0 || busy !== 1'b0)
      $display("FAIL idle_no_access: got acc=%0d busy=%b want 0/0", n_acc, busy); else passed++;
  endtask

  task automatic test_mask_write();
    pulse_start(18'h3FFFF);
    repeat (4) tick();
    total++; if (n_wr2 !== 1) $display("FAIL mask_wr_count: got %0d want 1", n_wr2); else passed++;
    total++; if (last_wr2 !== 32'h0003FFFF) $display("FAIL mask_wr_data: got %h want 0003ffff", last_wr2); else passed++;
    total++; if (n_acc !== 1 || busy !== 1'b0)
      $display("FAIL mask_wait_irq: got acc=%0d busy=%b want 1/0", n_acc, busy); else passed++;
  endtask

  task automatic test_edge_event();
    int acc0, clr0, lat;
    bit seen;
    acc0 = n_acc; clr0 = n_clr; lat = 0; seen = 1'b0;
    pio_in = 18'h3FFDF;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (pio_irq) seen = 1'b1;
    end
    total++; if (!seen) $display("FAIL edge_irq: got irq=0 want 1"); else passed++;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (evt_valid) break;
    end
    total++; if (lat !== 6) $display("FAIL edge_latency: got %0d want 6", lat); else passed++;
    total++; if (evt_edges !== 18'h00020 || evt_level !== 18'h3FFDF)
      $display("FAIL edge_entry: got edges=%h level=%h want 00020/3ffdf", evt_edges, evt_level); else passed++;
    total++; if (n_clr !== clr0 + 1 || n_acc !== acc0 + 3)
      $display("FAIL edge_bus: got clr=%0d acc=%0d want %0d/%0d", n_clr, n_acc, clr0 + 1, acc0 + 3); else passed++;
    total++; if (pio_irq !== 1'b0) $display("FAIL edge_cleared: got irq=%b want 0", pio_irq); else passed++;
    pio_in = '1;
    pop();
    total++; if (evt_valid !== 1'b0) $display("FAIL edge_pop: got valid=%b want 0", evt_valid); else passed++;
  endtask

  task automatic test_fifo_full();
    logic [W-1:0] exp_e [4];
    logic [W-1:0] exp_l [4];
    int acc0;
    exp_e = '{18'h00002, 18'h00004, 18'h00008, 18'h00050};
    exp_l = '{18'h3FFFD, 18'h3FFFB, 18'h3FFF7, 18'h3FFAF};
    evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) make_event(k);
    acc0 = n_acc;
    pio_in = 18'h3FFEF;
    repeat (5) tick();
    pio_in = 18'h3FFAF;
    repeat (20) tick();
    total++; if (pio_irq !== 1'b1 || n_acc !== acc0)
      $display("FAIL full_stall: got irq=%b acc=%0d want 1/%0d", pio_irq, n_acc, acc0); else passed++;
    total++; if (evt_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL full_state: got valid=%b busy=%b want 1/0", evt_valid, busy); else passed++;
    total++; if (evt_edges !== 18'h00001 || evt_level !== 18'h3FFFE)
      $display("FAIL full_head0: got edges=%h level=%h want 00001/3fffe", evt_edges, evt_level); else passed++;
    pop();
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (evt_valid !== 1'b1 || evt_edges !== exp_e[i] || evt_level !== exp_l[i])
        $display("FAIL full_drain%0d: got v=%b edges=%h level=%h want 1/%h/%h",
                 i, evt_valid, evt_edges, evt_level, exp_e[i], exp_l[i]); else passed++;
      pop();
    end
    total++; if (evt_valid !== 1'b0) $display("FAIL full_empty: got valid=%b want 0", evt_valid); else passed++;
    pio_in = '1;
    repeat (3) tick();
  endtask

  task automatic test_spurious();
    pulse_start(18'h00001);
    repeat (4) tick();
    total++; if (last_wr2 !== 32'h00000001) $display("FAIL spur_mask: got %h want 00000001", last_wr2); else passed++;
    pio_in = 18'h3FFF7;
    repeat (3) tick();
    total++; if (pio_irq !== 1'b0 || edgecap !== 18'h00008)
      $display("FAIL spur_masked_irq: got irq=%b cap=%h want 0/00008", pio_irq, edgecap); else passed++;
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    repeat (8) tick();
    total++; if (spurious_cnt !== 8'd1 || evt_valid !== 1'b0)
      $display("FAIL spur_one: got cnt=%0d valid=%b want 1/0", spurious_cnt, evt_valid); else passed++;
    total++; if (edgecap !== 18'h0) $display("FAIL spur_clear: got cap=%h want 0", edgecap); else passed++;
    force_irq = 1'b1;
    repeat (1600) tick();
    force_irq = 1'b0;
    repeat (8) tick();
    total++; if (spurious_cnt !== 8'd255 || evt_valid !== 1'b0)
      $display("FAIL spur_sat: got cnt=%0d valid=%b want 255/0", spurious_cnt, evt_valid); else passed++;
    pio_in = '1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int acc0, wr0;
    bit found;
    found = 1'b0;
    pulse_start(18'h3FFFF);
    repeat (4) tick();
    evt_ready = 1'b0;
    make_event(0);
    make_event(1);
    pio_in = 18'h3FFFB;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.m_chipselect && bus.m_write_n && bus.m_address == 2'd0) found = 1'b1;
    end
    total++; if (!found || evt_valid !== 1'b1)
      $display("FAIL rst_reach_rdlvl: got found=%b valid=%b want 1/1", found, evt_valid); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (evt_valid !== 1'b0 || busy !== 1'b0 || bus.m_chipselect !== 1'b0)
      $display("FAIL rst_async: got valid=%b busy=%b cs=%b want 0/0/0", evt_valid, busy, bus.m_chipselect); else passed++;
    pio_in = 18'h3FFF3;
    repeat (2) tick();
    reset_n = 1'b1;
    acc0 = n_acc; wr0 = n_wr2;
    repeat (20) tick();
    total++; if (n_acc !== acc0 || busy !== 1'b0 || pio_irq !== 1'b1)
      $display("FAIL rst_idle: got acc=%0d busy=%b irq=%b want %0d/0/1", n_acc, busy, pio_irq, acc0); else passed++;
    pio_in = 18'h3FFF7;
    pulse_start(18'h3FFFF);
    for (int i = 0; i < 20 && !evt_valid; i++) tick();
    total++; if (evt_valid !== 1'b1 || evt_edges !== 18'h00008 || evt_level !== 18'h3FFF7 || n_wr2 !== wr0 + 1)
      $display("FAIL rst_restart: got v=%b edges=%h level=%h wr=%0d want 1/00008/3fff7/%0d",
               evt_valid, evt_edges, evt_level, n_wr2, wr0 + 1); else passed++;
    pop();
    total++; if (evt_valid !== 1'b0) $display("FAIL rst_flushed: got valid=%b want 0", evt_valid); else passed++;
    pio_in = '1;
    repeat (2) tick();
  endtask

  task automatic test_start_in_rdcap();
    int wr0, iv, iw;
    bit found;
    wr0 = n_wr2; iv = -1; iw = -1; found = 1'b0;
    pio_in = 18'h3FF7F;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.m_chipselect && bus.m_write_n && bus.m_address == 2'd3) found = 1'b1;
    end
    total++; if (!found) $display("FAIL start_rdcap_seen: got 0 want 1"); else passed++;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (evt_valid && iv < 0) iv = i;
      if (n_wr2 != wr0 && iw < 0) iw = i;
    end
    total++; if (iv < 0 || iw !== iv + 1)
      $display("FAIL start_order: got push_at=%0d mask_at=%0d want mask one after push", iv, iw); else passed++;
    total++; if (evt_edges !== 18'h00080 || evt_level !== 18'h3FF7F || n_wr2 !== wr0 + 1)
      $display("FAIL start_entry: got edges=%h level=%h wr=%0d want 00080/3ff7f/%0d",
               evt_edges, evt_level, n_wr2, wr0 + 1); else passed++;
    pop();
    pio_in = '1;
  endtask

  initial begin
    test_reset();
    test_mask_write();
    test_edge_event();
    test_fifo_full();
    test_spurious();
    test_reset_mid();
    test_start_in_rdcap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pio_edge_event_sequencer.md
PIO_EDGE_EVENT_SEQUENCER -- requirements
Module: pio_edge_event_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 18, giving the PIO input/edge width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), giving the number of event FIFO entries.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_mask, input, WIDTH bits: irq mask to program into the PIO.
REQ-006 SHALL have port cfg_start, input, 1 bit: one-cycle pulse that (re)programs the mask and enables servicing.
REQ-007 SHALL have port pio_irq, input, 1 bit: PIO interrupt request.
REQ-008 SHALL have port m_address, output, 2 bits: PIO register address.
REQ-009 SHALL have port m_chipselect, output, 1 bit: PIO select.
REQ-010 SHALL have port m_write_n, output, 1 bit: active-low write strobe.
REQ-011 SHALL have port m_writedata, output, 32 bits: write data.
REQ-012 SHALL have port m_readdata, input, 32 bits: PIO read data, registered, valid exactly 1 cycle after the address is presented.
REQ-013 SHALL have port evt_valid, output, 1 bit: FIFO head is valid.
REQ-014 SHALL have port evt_ready, input, 1 bit: consumer accepts the head.
REQ-015 SHALL have port evt_edges, output, WIDTH bits: captured falling-edge bits of the head entry.
REQ-016 SHALL have port evt_level, output, WIDTH bits: input level snapshot of the head entry.
REQ-017 SHALL have port spurious_cnt, output, 8 bits: saturating count of empty (masked-zero) captures.
REQ-018 SHALL have port busy, output, 1 bit: high in every FSM state except IDLE and WAIT_IRQ.

Function
REQ-019 SHALL use FSM states IDLE, WR_MASK, WAIT_IRQ, RD_CAP, LATCH_CAP, WR_CLR, RD_LVL, LATCH_LVL, PUSH.
REQ-020 SHALL drive m_chipselect=0 and m_write_n=1 in IDLE, WAIT_IRQ, LATCH_LVL and PUSH.
REQ-021 SHALL move IDLE->WR_MASK on cfg_start; WR_MASK drives address 2, write_n=0, writedata={zero-extend cfg_mask} for 1 cycle, then -> WAIT_IRQ.
REQ-022 SHALL move WAIT_IRQ->RD_CAP when pio_irq=1 and the FIFO is not full; when the FIFO is full it SHALL remain in WAIT_IRQ and not access the PIO.
REQ-023 SHALL, in RD_CAP, drive address 3 as a read (chipselect=1, write_n=1) for 1 cycle, then -> LATCH_CAP.
REQ-024 SHALL, in LATCH_CAP, register m_readdata[WIDTH-1:0] & cfg_mask as the capture value and concurrently drive address 3, write_n=0, writedata=0 (clear); then -> RD_LVL.
REQ-025 SHALL treat WR_CLR as merged into LATCH_CAP; WR_CLR SHALL be an unreachable encoding and SHALL return to IDLE if ever entered.
REQ-026 SHALL, in RD_LVL, drive address 0 as a read; in LATCH_LVL, register m_readdata[WIDTH-1:0] as the level value.
REQ-027 SHALL, from LATCH_LVL, go to PUSH when the capture value is nonzero; otherwise it SHALL increment spurious_cnt (saturating at 255) and -> WAIT_IRQ.
REQ-028 SHALL, in PUSH, write {capture, level} into the FIFO in 1 cycle, then -> WAIT_IRQ.
REQ-029 SHALL give a cfg_start pulse in any state other than IDLE priority at the next state boundary: the current state completes, then the FSM -> WR_MASK; an in-flight capture SHALL still be pushed first if it has reached PUSH.
REQ-030 SHALL implement the FIFO as first-word fall-through: evt_valid=1 when not empty, the head is popped when evt_valid&evt_ready, and a simultaneous push and pop when full is impossible (REQ-022 guarantees a free slot).
REQ-031 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH and use an extra pointer bit to distinguish full from empty.
REQ-032 SHALL have a minimum latency of 6 cycles from pio_irq rising in WAIT_IRQ to evt_valid when the FIFO is empty.
REQ-033 SHALL accept the documented loss of an edge captured by the PIO exactly in the LATCH_CAP cycle, because the PIO clear has priority.

Reset
REQ-034 SHALL, while reset_n=0, force state=IDLE, FIFO empty, evt_valid=0, spurious_cnt=0, busy=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, and capture/level registers=0.
REQ-035 SHALL discard any in-flight transaction and all FIFO contents on reset asserted mid-operation, and SHALL require a new cfg_start after release.

Verification
REQ-036 SHALL verify: cfg_start with cfg_mask=0x3FFFF -> one write of 0x0003FFFF to address 2, then WAIT_IRQ.
REQ-037 SHALL verify: PIO in_port bit 5 falls, level=0x3FFDF -> evt_edges=0x00020 and evt_level=0x3FFDF, with an address 3 clear write observed.
REQ-038 SHALL verify: evt_ready=0 with 5 edge events at FIFO_DEPTH=4 -> 4 entries held, pio_irq stays high, no PIO access; after 1 pop, the 5th event (merged edges) is pushed.
REQ-039 SHALL verify: a capture that reads 0 after masking (cfg_mask=0x00001, bit 3 edge forced) -> no push, spurious_cnt=1; 300 such events -> spurious_cnt=255.
REQ-040 SHALL verify: reset_n pulsed low during RD_LVL with 2 FIFO entries -> evt_valid=0 and state IDLE, with no PIO access until cfg_start.
REQ-041 SHALL verify: cfg_start issued during RD_CAP -> capture completes and is pushed, then the mask write occurs.
